// File: rtl/conv_pkg.sv
// Constants and state encoding shared by the convolution scheduler, the Conv datapath
// and the image RAM.
package conv_pkg;

    localparam int unsigned IMG_W = 8;
    localparam int unsigned K     = 3;
    localparam int unsigned OUT_W = IMG_W - K + 1;

    typedef logic [2:0] state_t;

    localparam state_t StIdle   = 3'd0;
    localparam state_t StRun    = 3'd1;
    localparam state_t StFlush  = 3'd2;
    localparam state_t StResult = 3'd3;
    localparam state_t StDone   = 3'd4;

endpackage

// File: rtl/conv_window_sched_if.sv
// Control, RAM read and result handshake signals between the window scheduler and
// the surrounding datapath.
interface conv_window_sched_if #(
    parameter int unsigned ADDR_W = 6
);

    logic              start;
    logic              abort;
    logic              busy;
    logic              done;
    logic              ram_rd_en;
    logic [ADDR_W-1:0] ram_rd_addr;
    logic              mac_en;
    logic              mac_clr;
    logic [3:0]        coef_idx;
    logic              res_valid;
    logic              res_ready;
    logic [5:0]        res_idx;

    modport master (
        input  start, abort, res_ready,
        output busy, done, ram_rd_en, ram_rd_addr, mac_en, mac_clr, coef_idx,
               res_valid, res_idx
    );

    modport slave (
        output start, abort, res_ready,
        input  busy, done, ram_rd_en, ram_rd_addr, mac_en, mac_clr, coef_idx,
               res_valid, res_idx
    );

endinterface

// File: rtl/conv_win_counter.sv
// Row/column/tap counters walking the 3x3 windows of the image in row-major order.
module conv_win_counter #(
    parameter int unsigned OUT_W = 6,
    parameter int unsigned K     = 3,
    localparam int unsigned RcW  = (OUT_W > 1) ? $clog2(OUT_W) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clear,
    input  logic           tap_step,
    input  logic           win_step,
    output logic [RcW-1:0] row,
    output logic [RcW-1:0] col,
    output logic [3:0]     tap,
    output logic           last_tap,
    output logic           last_win
);

    logic [RcW-1:0] row_q, row_d;
    logic [RcW-1:0] col_q, col_d;
    logic [3:0]     tap_q, tap_d;

    assign last_tap = (tap_q == 4'(K * K - 1));
    assign last_win = (row_q == RcW'(OUT_W - 1)) && (col_q == RcW'(OUT_W - 1));

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        tap_d = tap_q;
        if (clear) begin
            row_d = '0;
            col_d = '0;
            tap_d = '0;
        end else begin
            if (tap_step) begin
                tap_d = last_tap ? 4'd0 : tap_q + 4'd1;
            end
            if (win_step) begin
                tap_d = 4'd0;
                if (col_q == RcW'(OUT_W - 1)) begin
                    col_d = '0;
                    row_d = row_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
            tap_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
            tap_q <= tap_d;
        end
    end

    assign row = row_q;
    assign col = col_q;
    assign tap = tap_q;

endmodule

// File: rtl/conv_window_sched.sv
// Sequences RAM reads and MAC strobes for every 3x3 window of the image and hands each
// finished window result to the consumer over a valid/ready handshake.
module conv_window_sched #(
    parameter int unsigned IMG_W  = conv_pkg::IMG_W,
    parameter int unsigned K      = conv_pkg::K,
    parameter int unsigned ADDR_W = 6,
    localparam int unsigned OUT_W = IMG_W - K + 1,
    localparam int unsigned RcW   = (OUT_W > 1) ? $clog2(OUT_W) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    conv_window_sched_if.master bus
);

    import conv_pkg::*;

    state_t         state_q, state_d;
    logic [RcW-1:0] row, col;
    logic [3:0]     tap;
    logic           last_tap, last_win;
    logic           cnt_clear, tap_step, win_step;
    logic           rd_en, abort_now;
    logic [ADDR_W:0] addr_full;
    logic           mac_en_q, mac_en_d;
    logic           mac_clr_q, mac_clr_d;
    logic [3:0]     coef_idx_q, coef_idx_d;

    conv_win_counter #(
        .OUT_W (OUT_W),
        .K     (K)
    ) u_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (cnt_clear),
        .tap_step (tap_step),
        .win_step (win_step),
        .row      (row),
        .col      (col),
        .tap      (tap),
        .last_tap (last_tap),
        .last_win (last_win)
    );

    assign abort_now = bus.abort && (state_q != StIdle);
    assign rd_en     = (state_q == StRun);

    always_comb begin
        state_d   = state_q;
        cnt_clear = 1'b0;
        tap_step  = 1'b0;
        win_step  = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d   = StRun;
                    cnt_clear = 1'b1;
                end
            end
            StRun: begin
                tap_step = 1'b1;
                if (last_tap) state_d = StFlush;
            end
            StFlush: state_d = StResult;
            StResult: begin
                if (bus.res_ready) begin
                    if (last_win) begin
                        state_d = StDone;
                    end else begin
                        win_step = 1'b1;
                        state_d  = StRun;
                    end
                end
            end
            StDone: begin
                state_d   = StIdle;
                cnt_clear = 1'b1;
            end
            default: state_d = StIdle;
        endcase
        if (abort_now) begin
            state_d   = StIdle;
            cnt_clear = 1'b1;
            tap_step  = 1'b0;
            win_step  = 1'b0;
        end
    end

    // Extra address bit keeps the sum from wrapping before the final truncation.
    always_comb begin
        addr_full = (ADDR_W + 1)'((32'(row) + 32'(tap) / K) * IMG_W + 32'(col) + 32'(tap) % K);
    end

    // One-cycle delay lines each MAC strobe up with the RAM data for its address.
    always_comb begin
        mac_en_d   = rd_en && !abort_now;
        mac_clr_d  = mac_en_d && (tap == 4'd0);
        coef_idx_d = mac_en_d ? tap : 4'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            mac_en_q   <= 1'b0;
            mac_clr_q  <= 1'b0;
            coef_idx_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            mac_en_q   <= mac_en_d;
            mac_clr_q  <= mac_clr_d;
            coef_idx_q <= coef_idx_d;
        end
    end

    assign bus.busy        = (state_q != StIdle);
    assign bus.done        = (state_q == StDone);
    assign bus.ram_rd_en   = rd_en;
    assign bus.ram_rd_addr = rd_en ? ADDR_W'(addr_full) : '0;
    assign bus.mac_en      = mac_en_q;
    assign bus.mac_clr     = mac_clr_q;
    assign bus.coef_idx    = coef_idx_q;
    assign bus.res_valid   = (state_q == StResult);
    assign bus.res_idx     = (state_q == StResult) ? 6'(32'(row) * OUT_W + 32'(col)) : 6'd0;

endmodule

// File: tb/tb_conv_window_sched.sv
// Scoreboard bench for conv_window_sched: expected reads, taps and result indices are
// queued at start and consumed as the scheduler produces them.
module tb_conv_window_sched;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    conv_window_sched_if #(.ADDR_W(6)) bus();

    conv_window_sched #(
        .IMG_W  (8),
        .K      (3),
        .ADDR_W (6)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int addr_q[$];
    int tap_q[$];
    int res_q[$];
    int pend_mac = 0;
    int pend_tap = 0;
    int mon_nxt, mon_nxt_tap;
    int first_rd_cycle, first_valid_cycle, last_hs_cycle, done_cycle;
    int done_cnt, stall_cnt, start_edge;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic clear_sb();
        addr_q.delete();
        tap_q.delete();
        res_q.delete();
    endtask

    task automatic push_pass();
        for (int w = 0; w < 36; w++) begin
            for (int t = 0; t < 9; t++) begin
                addr_q.push_back((w / 6 + t / 3) * 8 + w % 6 + t % 3);
                tap_q.push_back(t);
            end
            res_q.push_back(w);
        end
    endtask

    task automatic do_start();
        first_rd_cycle    = -1;
        first_valid_cycle = -1;
        last_hs_cycle     = -1;
        done_cycle        = -1;
        done_cnt          = 0;
        stall_cnt         = 0;
        @(posedge clk);
        #1 bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        start_edge = cyc;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (done_cnt == 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, int'(done_cnt > 0), 1);
    endtask

    task automatic wait_valid_idx(input string tag, input int idx, input int budget);
        int k = 0;
        while (!(bus.res_valid && int'(bus.res_idx) == idx) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, int'(k < budget), 1);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: cycle number of the current period is cyc+1.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            pend_mac = 0;
            pend_tap = 0;
        end else begin
            check("mac_en", int'(bus.mac_en), pend_mac);
            if (pend_mac != 0) begin
                check("coef_idx", int'(bus.coef_idx), pend_tap);
                check("mac_clr", int'(bus.mac_clr), int'(pend_tap == 0));
            end else begin
                check("mac_clr_idle", int'(bus.mac_clr), 0);
            end
            mon_nxt = 0;
            mon_nxt_tap = 0;
            if (bus.ram_rd_en) begin
                if (first_rd_cycle < 0) first_rd_cycle = cyc + 1;
                if (addr_q.size() == 0) begin
                    check("rd_extra", 1, 0);
                end else begin
                    check("rd_addr", int'(bus.ram_rd_addr), addr_q.pop_front());
                    mon_nxt_tap = tap_q.pop_front();
                    mon_nxt = int'(!bus.abort);
                end
            end
            pend_mac = mon_nxt;
            pend_tap = mon_nxt_tap;
            if (bus.res_valid) begin
                if (first_valid_cycle < 0) first_valid_cycle = cyc + 1;
                if (res_q.size() == 0) begin
                    check("res_extra", 1, 0);
                end else begin
                    check("res_idx", int'(bus.res_idx), res_q[0]);
                    if (bus.res_ready) begin
                        void'(res_q.pop_front());
                        last_hs_cycle = cyc + 1;
                    end else begin
                        stall_cnt++;
                        check("rd_in_stall", int'(bus.ram_rd_en), 0);
                    end
                end
            end
            if (bus.done) begin
                done_cnt++;
                done_cycle = cyc + 1;
            end
        end
    end

    initial begin
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.res_ready = 1'b1;
        rst_n         = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_rd_en", int'(bus.ram_rd_en), 0);
        check("rst_mac_en", int'(bus.mac_en), 0);
        check("rst_res_valid", int'(bus.res_valid), 0);
        check("rst_res_idx", int'(bus.res_idx), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Full pass with the consumer always ready.
        push_pass();
        do_start();
        @(negedge clk);
        check("busy_after_start", int'(bus.busy), 1);
        wait_done("done_pass1", 1000);
        check("first_rd_lat", first_rd_cycle - start_edge, 1);
        check("first_valid_lat", first_valid_cycle - start_edge, 11);
        check("pass_len", last_hs_cycle - first_rd_cycle + 1, 396);
        check("done_lat", done_cycle - start_edge, 397);
        @(negedge clk);
        @(negedge clk);
        check("busy_after_done", int'(bus.busy), 0);
        check("done_once", done_cnt, 1);
        check("sb_empty1", addr_q.size() + res_q.size(), 0);

        // Five stall cycles on result 3.
        push_pass();
        do_start();
        wait_valid_idx("reach_res2", 2, 100);
        @(posedge clk);
        #1 bus.res_ready = 1'b0;
        @(negedge clk);
        wait_valid_idx("reach_res3", 3, 50);
        repeat (5) @(posedge clk);
        #1 bus.res_ready = 1'b1;
        wait_done("done_bp", 1000);
        check("stall_cycles", stall_cnt, 5);
        check("pass_len_bp", last_hs_cycle - first_rd_cycle + 1, 401);
        check("done_lat_bp", done_cycle - start_edge, 402);
        check("sb_empty2", addr_q.size() + res_q.size(), 0);

        // Abort in the middle of window 10's reads.
        push_pass();
        do_start();
        wait_valid_idx("reach_res9", 9, 200);
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1 bus.abort = 1'b1;
        @(posedge clk);
        #1 bus.abort = 1'b0;
        clear_sb();
        @(negedge clk);
        check("abort_busy", int'(bus.busy), 0);
        check("abort_rd_en", int'(bus.ram_rd_en), 0);
        check("abort_coef", int'(bus.coef_idx), 0);
        check("abort_valid", int'(bus.res_valid), 0);
        check("abort_done", int'(bus.done), 0);
        repeat (5) @(negedge clk);
        check("abort_no_done", done_cnt, 0);
        push_pass();
        do_start();
        wait_done("done_after_abort", 1000);
        check("done_lat_restart", done_cycle - start_edge, 397);

        // Start while busy is ignored; async reset clears a pending result.
        repeat (2) @(negedge clk);
        bus.res_ready = 1'b0;
        push_pass();
        do_start();
        repeat (3) @(posedge clk);
        #1 bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        wait_valid_idx("reach_res0", 0, 50);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_valid", int'(bus.res_valid), 0);
        check("async_rst_busy", int'(bus.busy), 0);
        clear_sb();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.res_ready = 1'b1;
        repeat (20) @(negedge clk);
        check("post_rst_busy", int'(bus.busy), 0);
        check("post_rst_valid", int'(bus.res_valid), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
